// File: rtl/int0_result_buffer.sv
// In-order result buffer between the Int0 shifter and register-file writeback.
// Retiring entries optionally update the architectural Int0 condition-code register.
module int0_result_buffer #(
   parameter int DEPTH = 2,
   parameter int TAG_W = 5
) (
   input  logic                       clk_i_rb,
   input  logic                       rst_n_i_rb,
   input  logic                       valid_i_rb,
   output logic                       ready_o_rb,
   input  logic [31:0]                rslt_i_rb,
   input  logic [1:0]                 cc_i_rb,
   input  logic                       cc_we_i_rb,
   input  logic [TAG_W-1:0]           dst_i_rb,
   input  logic                       flush_i_rb,
   output logic                       wb_valid_o_rb,
   input  logic                       wb_ready_i_rb,
   output logic [31:0]                wb_data_o_rb,
   output logic [TAG_W-1:0]           wb_dst_o_rb,
   output logic [1:0]                 cc_o_rb,
   output logic [$clog2(DEPTH):0]     count_o_rb
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   // Entry storage; deliberately not reset, contents are qualified by count.
   logic [31:0]      mem_rslt [DEPTH];
   logic [1:0]       mem_cc   [DEPTH];
   logic             mem_we   [DEPTH];
   logic [TAG_W-1:0] mem_dst  [DEPTH];

   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [1:0]       cc_reg, cc_next;

   logic push;
   logic pop;
   logic head_cc_we;
   logic [1:0] head_cc;

   assign ready_o_rb    = (count_reg < DEPTH_C);
   assign wb_valid_o_rb = (count_reg != '0);

   assign push = valid_i_rb & ready_o_rb & ~flush_i_rb;
   assign pop  = wb_valid_o_rb & wb_ready_i_rb & ~flush_i_rb;

   assign wb_data_o_rb = mem_rslt[rd_ptr_reg];
   assign wb_dst_o_rb  = mem_dst[rd_ptr_reg];
   assign head_cc      = mem_cc[rd_ptr_reg];
   assign head_cc_we   = mem_we[rd_ptr_reg];

   assign cc_o_rb    = cc_reg;
   assign count_o_rb = count_reg;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      cc_next     = cc_reg;
      if (flush_i_rb) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
            if (head_cc_we) begin
               cc_next = head_cc;
            end
         end
         case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk_i_rb) begin
      if (!rst_n_i_rb) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         cc_reg     <= 2'b00;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         cc_reg     <= cc_next;
      end
   end

   // push already excludes reset-free hazards: a write during reset is harmless.
   always_ff @(posedge clk_i_rb) begin
      if (push) begin
         mem_rslt[wr_ptr_reg] <= rslt_i_rb;
         mem_cc[wr_ptr_reg]   <= cc_i_rb;
         mem_we[wr_ptr_reg]   <= cc_we_i_rb;
         mem_dst[wr_ptr_reg]  <= dst_i_rb;
      end
   end

endmodule

// File: tb/tb_int0_result_buffer.sv
// Directed bench for int0_result_buffer: vector table plus a streaming scoreboard run.
module tb_int0_result_buffer;

   logic        clk;
   logic        rst_n;
   logic        valid;
   logic        ready;
   logic [31:0] rslt;
   logic [1:0]  cc;
   logic        cc_we;
   logic [4:0]  dst;
   logic        flush;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_dst;
   logic [1:0]  cc_out;
   logic [1:0]  count;

   int n_checks = 0;
   int n_pass   = 0;

   int0_result_buffer #(.DEPTH(2), .TAG_W(5)) dut (
      .clk_i_rb      (clk),
      .rst_n_i_rb    (rst_n),
      .valid_i_rb    (valid),
      .ready_o_rb    (ready),
      .rslt_i_rb     (rslt),
      .cc_i_rb       (cc),
      .cc_we_i_rb    (cc_we),
      .dst_i_rb      (dst),
      .flush_i_rb    (flush),
      .wb_valid_o_rb (wb_valid),
      .wb_ready_i_rb (wb_ready),
      .wb_data_o_rb  (wb_data),
      .wb_dst_o_rb   (wb_dst),
      .cc_o_rb       (cc_out),
      .count_o_rb    (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rst_n, vld;
      logic [31:0] rslt;
      logic [1:0]  cc;
      logic        ccwe;
      logic [4:0]  dst;
      logic        flush, wbr;
      logic        chk, e_rdy, e_wbv;
      logic [31:0] e_data;
      logic [4:0]  e_dst;
      logic [1:0]  e_cc;
      logic [1:0]  e_cnt;
   } vec_t;

   localparam int NVEC = 31;
   vec_t tbl [NVEC];

   function automatic vec_t mk(
      logic r, logic v, logic [31:0] d, logic [1:0] c, logic w, logic [4:0] t,
      logic f, logic wr, logic k, logic er, logic ev, logic [31:0] ed,
      logic [4:0] et, logic [1:0] ec, logic [1:0] en);
      vec_t x;
      x.rst_n = r;  x.vld = v;  x.rslt = d;  x.cc = c;  x.ccwe = w;  x.dst = t;
      x.flush = f;  x.wbr = wr; x.chk = k;   x.e_rdy = er; x.e_wbv = ev;
      x.e_data = ed; x.e_dst = et; x.e_cc = ec; x.e_cnt = en;
      return x;
   endfunction

   task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s step%0d: got %h expected %h", nm, idx, act, exp);
      else
         n_pass++;
   endtask

   logic [31:0] sb_q[$];
   int next_val, retired, cnt_m;
   logic tog, m_push, m_pop;

   initial begin
      //            rst vld rslt   cc we dst fl wbr | chk rdy wbv data   dst cc cnt
      tbl[0]  = mk(0, 0, 0,      0, 0, 0,  0, 0,   0, 0, 0, 0,     0,  0, 0);
      tbl[1]  = mk(1, 0, 0,      0, 0, 0,  0, 0,   1, 1, 0, 0,     0,  0, 0);
      tbl[2]  = mk(1, 1, 'hF0,   0, 1, 3,  0, 1,   1, 1, 0, 0,     0,  0, 0);
      tbl[3]  = mk(1, 0, 0,      0, 0, 0,  0, 1,   1, 1, 1, 'hF0,  3,  0, 1);
      tbl[4]  = mk(1, 0, 0,      0, 0, 0,  0, 0,   1, 1, 0, 0,     0,  0, 0);
      tbl[5]  = mk(1, 1, 'h11,   1, 0, 1,  0, 0,   1, 1, 0, 0,     0,  0, 0);
      tbl[6]  = mk(1, 1, 'h22,   0, 0, 2,  0, 0,   1, 1, 1, 'h11,  1,  0, 1);
      tbl[7]  = mk(1, 1, 'h33,   2, 1, 3,  0, 0,   1, 0, 1, 'h11,  1,  0, 2);
      tbl[8]  = mk(1, 0, 0,      0, 0, 0,  0, 1,   1, 0, 1, 'h11,  1,  0, 2);
      tbl[9]  = mk(1, 0, 0,      0, 0, 0,  0, 1,   1, 1, 1, 'h22,  2,  0, 1);
      tbl[10] = mk(1, 0, 0,      0, 0, 0,  0, 0,   1, 1, 0, 0,     0,  0, 0);
      tbl[11] = mk(1, 1, 0,      1, 1, 4,  0, 0,   1, 1, 0, 0,     0,  0, 0);
      tbl[12] = mk(1, 1, 5,      0, 0, 5,  0, 0,   1, 1, 1, 0,     4,  0, 1);
      tbl[13] = mk(1, 0, 0,      0, 0, 0,  0, 1,   1, 0, 1, 0,     4,  0, 2);
      tbl[14] = mk(1, 0, 0,      0, 0, 0,  0, 1,   1, 1, 1, 5,     5,  1, 1);
      tbl[15] = mk(1, 0, 0,      0, 0, 0,  0, 0,   1, 1, 0, 0,     0,  1, 0);
      tbl[16] = mk(1, 1, 'hAA,   2, 1, 6,  0, 0,   1, 1, 0, 0,     0,  1, 0);
      tbl[17] = mk(1, 1, 'hBB,   3, 1, 7,  0, 0,   1, 1, 1, 'hAA,  6,  1, 1);
      tbl[18] = mk(1, 1, 'hCC,   2, 1, 8,  1, 1,   1, 0, 1, 'hAA,  6,  1, 2);
      tbl[19] = mk(1, 0, 0,      0, 0, 0,  0, 0,   1, 1, 0, 0,     0,  1, 0);
      tbl[20] = mk(1, 1, 'hDD,   2, 1, 9,  1, 1,   1, 1, 0, 0,     0,  1, 0);
      tbl[21] = mk(1, 0, 0,      0, 0, 0,  0, 0,   1, 1, 0, 0,     0,  1, 0);
      tbl[22] = mk(1, 1, 'hEE,   2, 1, 10, 0, 0,   1, 1, 0, 0,     0,  1, 0);
      tbl[23] = mk(0, 0, 0,      0, 0, 0,  0, 1,   1, 1, 1, 'hEE,  10, 1, 1);
      tbl[24] = mk(1, 0, 0,      0, 0, 0,  0, 0,   1, 1, 0, 0,     0,  0, 0);
      tbl[25] = mk(1, 1, 'h01,   3, 1, 11, 0, 0,   1, 1, 0, 0,     0,  0, 0);
      tbl[26] = mk(1, 1, 'h02,   2, 1, 12, 0, 0,   1, 1, 1, 'h01,  11, 0, 1);
      tbl[27] = mk(1, 1, 'h03,   1, 1, 13, 0, 1,   1, 0, 1, 'h01,  11, 0, 2);
      tbl[28] = mk(1, 0, 0,      0, 0, 0,  0, 0,   1, 1, 1, 'h02,  12, 3, 1);
      tbl[29] = mk(1, 0, 0,      0, 0, 0,  0, 1,   1, 1, 1, 'h02,  12, 3, 1);
      tbl[30] = mk(1, 0, 0,      0, 0, 0,  0, 0,   1, 1, 0, 0,     0,  2, 0);

      rst_n = 1'b0; valid = 1'b0; rslt = '0; cc = '0; cc_we = 1'b0;
      dst = '0; flush = 1'b0; wb_ready = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         rst_n = tbl[i].rst_n; valid = tbl[i].vld; rslt = tbl[i].rslt;
         cc = tbl[i].cc; cc_we = tbl[i].ccwe; dst = tbl[i].dst;
         flush = tbl[i].flush; wb_ready = tbl[i].wbr;
         #1;
         $display("vec %0d: rst_n=%b vld=%b rslt=%h fl=%b wbr=%b | rdy=%b wbv=%b data=%h dst=%0d cc=%b cnt=%0d",
                  i, rst_n, valid, rslt, flush, wb_ready, ready, wb_valid, wb_data, wb_dst, cc_out, count);
         if (tbl[i].chk) begin
            check("ready", i, 32'(ready), 32'(tbl[i].e_rdy));
            check("wb_valid", i, 32'(wb_valid), 32'(tbl[i].e_wbv));
            check("cc_o", i, 32'(cc_out), 32'(tbl[i].e_cc));
            check("count", i, 32'(count), 32'(tbl[i].e_cnt));
            if (tbl[i].e_wbv) begin
               check("wb_data", i, wb_data, tbl[i].e_data);
               check("wb_dst", i, 32'(wb_dst), 32'(tbl[i].e_dst));
            end
         end
      end

      // Streaming 1..6 with alternating writeback ready, checked against a queue model.
      next_val = 1; retired = 0; cnt_m = 0; tog = 1'b1;
      for (int cyc = 0; cyc < 60 && retired < 6; cyc++) begin
         @(negedge clk);
         rst_n = 1'b1; flush = 1'b0; cc_we = 1'b0; cc = 2'b00;
         valid = (next_val <= 6);
         rslt = 32'(next_val);
         dst = 5'(next_val);
         wb_ready = tog;
         #1;
         check("stream_count", cyc, 32'(count), 32'(cnt_m));
         check("stream_ready", cyc, 32'(ready), 32'(cnt_m < 2));
         check("stream_wbv", cyc, 32'(wb_valid), 32'(cnt_m != 0));
         m_push = valid && (cnt_m < 2);
         m_pop  = (cnt_m != 0) && wb_ready;
         if (m_pop) begin
            check("stream_data", cyc, wb_data, sb_q[0]);
            $display("stream %0d: retire %h (cnt=%0d)", cyc, wb_data, count);
            void'(sb_q.pop_front());
            retired++;
         end
         if (m_push) begin
            sb_q.push_back(32'(next_val));
            next_val++;
         end
         cnt_m = cnt_m + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
         tog = ~tog;
      end
      check("stream_retired", 0, 32'(retired), 32'd6);

      @(negedge clk);
      valid = 1'b0; wb_ready = 1'b0;
      #1;
      check("stream_drained", 0, 32'(count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/int0_result_buffer.md
Name: int0_result_buffer

Overview:
- Downstream stage of the Exe0/Int0 shifter. Captures each shifter result (32-bit value, 2-bit condition code, destination tag) into a small in-order FIFO.
- Drains the FIFO to the register-file writeback port with a valid/ready handshake.
- Maintains the architectural Int0 condition-code register, updated as entries retire.
- Decouples shifter issue from writeback stalls; flushable on pipeline cancel.

Parameters:
- DEPTH, 2, number of buffer entries (power of two, 2..8).
- TAG_W, 5, destination register tag width.

Ports:
- clk_i_rb  in  1  clock; all state updates on rising edge.
- rst_n_i_rb  in  1  reset, synchronous, active-low.
- valid_i_rb  in  1  shifter result valid.
- ready_o_rb  out  1  buffer can accept this cycle.
- rslt_i_rb  in  32  shifter result (rslt_o_sh).
- cc_i_rb  in  2  shifter condition code (rslt_cc_o_sh; bit0 = zero).
- cc_we_i_rb  in  1  this result updates the CC register.
- dst_i_rb  in  TAG_W  destination register tag.
- flush_i_rb  in  1  discard all buffered, not-yet-retired entries.
- wb_valid_o_rb  out  1  head entry presented to writeback.
- wb_ready_i_rb  in  1  writeback accepts head entry.
- wb_data_o_rb  out  32  head entry result.
- wb_dst_o_rb  out  TAG_W  head entry tag.
- cc_o_rb  out  2  architectural CC register.
- count_o_rb  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
Reset (rst_n_i_rb low at a clock edge):
- Count, read pointer and write pointer go to 0. cc_o_rb goes to 2'b00.
- wb_valid_o_rb is 0 and ready_o_rb is 1 from the next cycle.
- Reset mid-operation discards all entries with no retirement.
- Entry storage is not reset. wb_data_o_rb and wb_dst_o_rb are don't-care while wb_valid_o_rb is 0; the bench must not check them then.

Push and pop rules:
- push = valid_i_rb & ready_o_rb & ~flush_i_rb. The entry {rslt, cc, cc_we, dst} is written at wr_ptr and wr_ptr increments modulo DEPTH.
- ready_o_rb = (count < DEPTH). It depends only on registered state, with no combinational path from wb_ready_i_rb.
- pop = wb_valid_o_rb & wb_ready_i_rb & ~flush_i_rb. rd_ptr increments modulo DEPTH.
- wb_valid_o_rb = (count != 0). Head fields are driven combinationally from the entry at rd_ptr.
- Latency: a result pushed into an empty buffer appears on wb_* in the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Full (count == DEPTH): ready_o_rb = 0; valid_i_rb is ignored. A pop in that cycle frees a slot usable from the next cycle.
- Empty: a pop cannot occur because wb_valid_o_rb = 0.
- Pointer wrap: pointers wrap modulo DEPTH. Ordering is strictly FIFO across the wrap.
- Holding: while wb_valid_o_rb is 1 and wb_ready_i_rb is 0, the head fields are stable.

CC register:
- On pop of an entry whose cc_we is 1, cc_o_rb <= that entry's cc in the same edge.
- Entries with cc_we = 0 leave cc_o_rb unchanged.

Flush:
- flush_i_rb = 1 at an edge sets count and both pointers to 0. The edge's push and pop are both suppressed and cc_o_rb is unchanged.
- Flush has priority over everything except reset.
- ready_o_rb may be 1 during flush, but input is ignored that cycle.

count_o_rb equals the registered count.

Test Plan:
- Reset then single push (rslt=32'h0000_00F0, cc=2'b00, cc_we=1, dst=5'd3), wb_ready=1 -> wb_valid high exactly one cycle later with data 0xF0 and dst 3; after the pop, cc_o=2'b00 and count returns to 0.
- Fill with wb_ready=0: push 0x11 then 0x22 -> count=2 and ready_o=0; a third valid 0x33 is ignored. Then wb_ready=1 -> retires 0x11 then 0x22 in order, and 0x33 never appears.
- Continuous streaming of 6 pushes 0x1..0x6 with wb_ready toggling 1,0,1,0… -> all six retire in order across pointer wrap; no loss or duplication; count never exceeds 2.
- CC update: push A (rslt 0, cc=2'b01, cc_we=1), then B (rslt 5, cc=2'b00, cc_we=0) -> cc_o=2'b01 after A retires and stays 2'b01 after B retires.
- Flush with count=2 while valid_i=1 and wb_ready=1 -> next cycle count=0 and wb_valid=0; neither the incoming nor the head entry retires; cc_o unchanged.
- Reset asserted mid-stream with count=1 -> next cycle wb_valid=0, count=0, cc_o=2'b00, ready_o=1.
